// File: rtl/atari_timing_pkg.sv
// Shared timing constants and lock-state type for the Atari 2600 clock scheduler.
package atari_timing_pkg;

  // Pixel clocks per CPU machine cycle and strobe positions within a slot
  localparam int SLOT_LEN  = 21;
  localparam int TIA_PH1   = 7;
  localparam int PIA_PH    = 16;

  // VGA horizontal position where the slot is realigned to the scanline
  localparam int HRESYNC_X = 798;

  // Bus widths
  localparam int SLOT_W    = 5;
  localparam int HPOS_W    = 10;
  localparam int LINE_W    = 10;
  localparam int MISS_W    = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/atari_frame_lock.sv
// Frame-lock controller: vsync edge detection, HOLD state machine, line counter
// and saturating count of holds that ended by timeout instead of VGA vsync.
module atari_frame_lock
  import atari_timing_pkg::*;
#(
  parameter int TIMEOUT_LINES = 600
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_line_tick,
  input  logic              i_vga_vsync,
  input  logic              i_tia_vsync,
  input  logic              i_lock_en,
  output logic              o_run_n,
  output logic              o_holding,
  output logic              o_locked,
  output logic [MISS_W-1:0] o_miss_count
);

  lock_state_t       r_state;
  lock_state_t       w_state_n;
  logic              r_prev_tia;
  logic              r_prev_vga;
  logic [LINE_W-1:0] r_lines;
  logic [LINE_W-1:0] w_lines_n;
  logic              r_locked;
  logic              w_locked_n;
  logic [MISS_W-1:0] r_miss;
  logic [MISS_W-1:0] w_miss_n;
  logic              w_tia_fall;
  logic              w_vga_rise;

  assign w_tia_fall = r_prev_tia & ~i_tia_vsync;
  assign w_vga_rise = ~r_prev_vga & i_vga_vsync;

  // State, counters and previous-vsync samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= RUN;
      r_prev_tia <= 1'b0;
      r_prev_vga <= 1'b0;
      r_lines    <= '0;
      r_locked   <= 1'b0;
      r_miss     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_prev_tia <= i_tia_vsync;
      r_prev_vga <= i_vga_vsync;
      r_lines    <= w_lines_n;
      r_locked   <= w_locked_n;
      r_miss     <= w_miss_n;
    end
  end

  // Next state: a TIA frame end parks the machine until the VGA frame starts;
  // VGA vsync wins over timeout, timeout wins over a dropped lock_en.
  always_comb begin
    w_state_n  = r_state;
    w_lines_n  = r_lines;
    w_locked_n = r_locked;
    w_miss_n   = r_miss;
    case (r_state)
      RUN: begin
        if (!i_lock_en) begin
          w_locked_n = 1'b0;
        end else if (w_tia_fall && w_vga_rise) begin
          w_locked_n = 1'b1;
        end else if (w_tia_fall) begin
          w_state_n = HOLD;
          w_lines_n = '0;
        end
      end
      HOLD: begin
        w_lines_n = r_lines + LINE_W'(i_line_tick);
        if (w_vga_rise) begin
          w_state_n  = RUN;
          w_locked_n = 1'b1;
        end else if (w_lines_n >= LINE_W'(TIMEOUT_LINES)) begin
          w_state_n  = RUN;
          w_locked_n = 1'b0;
          w_miss_n   = (r_miss == {MISS_W{1'b1}}) ? r_miss : r_miss + MISS_W'(1);
        end else if (!i_lock_en) begin
          w_state_n  = RUN;
          w_locked_n = 1'b0;
        end
      end
      default: w_state_n = RUN;
    endcase
  end

  assign o_run_n      = (w_state_n == RUN);
  assign o_holding    = (r_state == HOLD);
  assign o_locked     = r_locked;
  assign o_miss_count = r_miss;

endmodule

// File: rtl/atari_clock_scheduler.sv
// Clock-enable scheduler for the Atari 2600 core on the VGA pixel clock:
// 21-clock machine slot, registered TIA/CPU/PIA strobes, scanline realignment,
// line-buffer bank select and frame lock against the VGA raster.
module atari_clock_scheduler
  import atari_timing_pkg::*;
#(
  parameter int TIMEOUT_LINES = 600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HPOS_W-1:0] vga_hpos,
  input  logic              vga_vsync,
  input  logic              tia_vsync,
  input  logic              lock_en,
  output logic              tia_en,
  output logic              cpu_en,
  output logic              cpu_phase,
  output logic              pia_en,
  output logic [SLOT_W-1:0] slot,
  output logic              line_bank,
  output logic              holding,
  output logic              locked,
  output logic [MISS_W-1:0] miss_count
);

  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_n;
  logic              w_resync;
  logic              w_line_tick;
  logic              w_run_n;
  logic              w_new_slot;
  logic              w_tia_hit;
  logic              r_tia_en;
  logic              r_cpu_en;
  logic              r_cpu_phase;
  logic              r_pia_en;
  logic              r_line_bank;

  assign w_resync    = (vga_hpos >= HPOS_W'(HRESYNC_X));
  assign w_line_tick = (vga_hpos == HPOS_W'(HRESYNC_X));

  // Next slot: scanline realignment overrides the normal wrap.
  always_comb begin
    w_slot_n = r_slot + SLOT_W'(1);
    if (w_resync || (r_slot == SLOT_W'(SLOT_LEN - 1))) begin
      w_slot_n = '0;
    end
  end

  // Strobes fire only when the slot actually advances, so the resync dwell
  // at slot 0 at the end of each line does not stretch or repeat a pulse.
  assign w_new_slot = (w_slot_n != r_slot);
  assign w_tia_hit  = (w_slot_n == SLOT_W'(0)) ||
                      (w_slot_n == SLOT_W'(TIA_PH1)) ||
                      (w_slot_n == SLOT_W'(2 * TIA_PH1));

  atari_frame_lock #(
    .TIMEOUT_LINES (TIMEOUT_LINES)
  ) u_frame_lock (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_line_tick  (w_line_tick),
    .i_vga_vsync  (vga_vsync),
    .i_tia_vsync  (tia_vsync),
    .i_lock_en    (lock_en),
    .o_run_n      (w_run_n),
    .o_holding    (holding),
    .o_locked     (locked),
    .o_miss_count (miss_count)
  );

  // Slot counter, registered enables and line-buffer bank toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot      <= '0;
      r_tia_en    <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_cpu_phase <= 1'b0;
      r_pia_en    <= 1'b0;
      r_line_bank <= 1'b0;
    end else begin
      r_slot      <= w_slot_n;
      r_tia_en    <= w_run_n & w_new_slot & w_tia_hit;
      r_cpu_en    <= w_run_n & w_new_slot & (w_slot_n == SLOT_W'(0));
      r_pia_en    <= w_run_n & w_new_slot & (w_slot_n == SLOT_W'(PIA_PH));
      r_cpu_phase <= w_run_n & (w_slot_n < SLOT_W'(PIA_PH));
      if (w_line_tick) begin
        r_line_bank <= ~r_line_bank;
      end
    end
  end

  assign slot      = r_slot;
  assign tia_en    = r_tia_en;
  assign cpu_en    = r_cpu_en;
  assign cpu_phase = r_cpu_phase;
  assign pia_en    = r_pia_en;
  assign line_bank = r_line_bank;

endmodule

// File: tb/tb_atari_clock_scheduler.sv
// Bench for atari_clock_scheduler: directed scenarios plus random traffic,
// all outputs compared every clock against a behavioural model.
module tb_atari_clock_scheduler;

  localparam int HX       = 798;
  localparam int TO_LINES = 600;
  localparam int SAT_TO   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] vga_hpos = '0;
  logic       vga_vsync = 1'b0;
  logic       tia_vsync = 1'b0;
  logic       lock_en = 1'b0;
  logic       tia_en, cpu_en, cpu_phase, pia_en, line_bank, holding, locked;
  logic [4:0] slot;
  logic [7:0] miss_count;

  logic [9:0] s_hpos = '0;
  logic       s_vsync = 1'b0;
  logic       s_tvsync = 1'b0;
  logic       s_lock = 1'b0;
  logic       s_tia, s_cpu, s_phase, s_pia, s_bank, s_hold, s_locked;
  logic [4:0] s_slot;
  logic [7:0] s_miss;

  atari_clock_scheduler dut (
    .clk(clk), .reset(reset), .vga_hpos(vga_hpos), .vga_vsync(vga_vsync),
    .tia_vsync(tia_vsync), .lock_en(lock_en), .tia_en(tia_en), .cpu_en(cpu_en),
    .cpu_phase(cpu_phase), .pia_en(pia_en), .slot(slot), .line_bank(line_bank),
    .holding(holding), .locked(locked), .miss_count(miss_count)
  );

  atari_clock_scheduler #(.TIMEOUT_LINES(SAT_TO)) dut_sat (
    .clk(clk), .reset(reset), .vga_hpos(s_hpos), .vga_vsync(s_vsync),
    .tia_vsync(s_tvsync), .lock_en(s_lock), .tia_en(s_tia), .cpu_en(s_cpu),
    .cpu_phase(s_phase), .pia_en(s_pia), .slot(s_slot), .line_bank(s_bank),
    .holding(s_hold), .locked(s_locked), .miss_count(s_miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  int m_slot, m_hold, m_lines, m_locked, m_miss, m_bank, m_ptv, m_pvv;
  int e_tia, e_cpu, e_pia, e_ph;
  int g_hp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int nh();
    int h;
    h = g_hp;
    g_hp = (g_hp + 1) % 800;
    return h;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_hold = 0; m_lines = 0; m_locked = 0; m_miss = 0;
    m_bank = 0; m_ptv = 0; m_pvv = 0;
    e_tia = 0; e_cpu = 0; e_pia = 0; e_ph = 0;
  endtask

  task automatic check_reset_vals(input string ph);
    chk({ph, "_tia"}, 32'(tia_en), 0);
    chk({ph, "_cpu"}, 32'(cpu_en), 0);
    chk({ph, "_phase"}, 32'(cpu_phase), 0);
    chk({ph, "_pia"}, 32'(pia_en), 0);
    chk({ph, "_slot"}, 32'(slot), 0);
    chk({ph, "_bank"}, 32'(line_bank), 0);
    chk({ph, "_hold"}, 32'(holding), 0);
    chk({ph, "_locked"}, 32'(locked), 0);
    chk({ph, "_miss"}, 32'(miss_count), 0);
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_tia"}, 32'(tia_en), e_tia);
    chk({ph, "_cpu"}, 32'(cpu_en), e_cpu);
    chk({ph, "_phase"}, 32'(cpu_phase), e_ph);
    chk({ph, "_pia"}, 32'(pia_en), e_pia);
    chk({ph, "_slot"}, 32'(slot), m_slot);
    chk({ph, "_bank"}, 32'(line_bank), m_bank);
    chk({ph, "_hold"}, 32'(holding), m_hold);
    chk({ph, "_locked"}, 32'(locked), m_locked);
    chk({ph, "_miss"}, 32'(miss_count), m_miss);
  endtask

  // One pixel clock: drive inputs, advance the model, then compare.
  task automatic tick(input int hp, input int vv, input int tv, input int le);
    int sn, tf, vr, hold_n;
    vga_hpos  = 10'(hp);
    vga_vsync = (vv != 0);
    tia_vsync = (tv != 0);
    lock_en   = (le != 0);
    tf = (m_ptv == 1 && tv == 0) ? 1 : 0;
    vr = (m_pvv == 0 && vv == 1) ? 1 : 0;
    sn = (hp >= HX) ? 0 : (m_slot + 1) % 21;
    hold_n = m_hold;
    if (m_hold == 0) begin
      if (le == 0) m_locked = 0;
      else if (tf == 1 && vr == 1) m_locked = 1;
      else if (tf == 1) begin hold_n = 1; m_lines = 0; end
    end else begin
      if (hp == HX) m_lines = m_lines + 1;
      if (vr == 1) begin hold_n = 0; m_locked = 1; end
      else if (m_lines >= TO_LINES) begin
        hold_n = 0; m_locked = 0;
        if (m_miss < 255) m_miss = m_miss + 1;
      end else if (le == 0) begin hold_n = 0; m_locked = 0; end
    end
    e_tia = (hold_n == 0 && sn != m_slot && sn % 7 == 0) ? 1 : 0;
    e_cpu = (hold_n == 0 && sn != m_slot && sn == 0) ? 1 : 0;
    e_pia = (hold_n == 0 && sn != m_slot && sn == 16) ? 1 : 0;
    e_ph  = (hold_n == 0 && sn < 16) ? 1 : 0;
    if (hp == HX) m_bank = 1 - m_bank;
    m_slot = sn;
    m_hold = hold_n;
    m_ptv = tv;
    m_pvv = vv;
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_tia, n_flip, n_en, n_lost, n_rs, cyc, first, pb, h, tv, vv, le;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    // Power-up slot sequence with hpos at 0
    for (int e = 1; e <= 21; e++) begin
      tick(0, 0, 0, 0);
      if (e == 7 || e == 14 || e == 21) chk("pu_tia", 32'(tia_en), 1);
      if (e == 16) chk("pu_pia", 32'(pia_en), 1);
      if (e == 21) begin
        chk("pu_cpu", 32'(cpu_en), 1);
        chk("pu_slot0", 32'(slot), 0);
      end
      chk("pu_phase", 32'(cpu_phase), (e <= 15 || e == 21) ? 1 : 0);
    end

    // Scanline sweep
    n_tia = 0; n_flip = 0; g_hp = 0;
    for (int c = 0; c < 3200; c++) begin
      pb = int'(line_bank);
      h = nh();
      tick(h, 0, 0, 0);
      n_tia += int'(tia_en);
      if (int'(line_bank) != pb) n_flip++;
      if (h >= HX) chk("sweep_slot0", 32'(slot), 0);
    end
    chk("sweep_tia_count", n_tia, 456);
    chk("sweep_bank_flips", n_flip, 4);

    // Hold released by VGA vsync
    tick(nh(), 0, 1, 1);
    tick(nh(), 0, 0, 1);
    chk("hold_enter", 32'(holding), 1);
    n_en = 0; n_lost = 0;
    repeat (1000) begin
      tick(nh(), 0, 0, 1);
      n_en += int'(tia_en | cpu_en | pia_en | cpu_phase);
      if (!holding) n_lost++;
    end
    chk("hold_no_enables", n_en, 0);
    chk("hold_kept", n_lost, 0);
    tick(nh(), 1, 0, 1);
    chk("hold_exit", 32'(holding), 0);
    chk("hold_locked", 32'(locked), 1);
    chk("hold_miss", 32'(miss_count), 0);
    tick(nh(), 0, 0, 1);

    // Hold timeout with no VGA vsync
    tick(0, 0, 1, 1);
    tick(0, 0, 0, 1);
    chk("to_enter", 32'(holding), 1);
    cyc = 0; n_rs = 0;
    while (holding && cyc < 5000) begin
      h = ($urandom_range(0, 1) == 1) ? HX : int'($urandom_range(0, 799));
      if (h == HX) n_rs++;
      tick(h, 0, 0, 1);
      cyc++;
    end
    chk("to_exit", 32'(holding), 0);
    chk("to_resyncs", n_rs, TO_LINES);
    chk("to_locked", 32'(locked), 0);
    chk("to_miss", 32'(miss_count), 1);

    // Coincident TIA fall and VGA rise
    tick(0, 0, 1, 1);
    tick(1, 1, 0, 1);
    chk("same_run", 32'(holding), 0);
    chk("same_locked", 32'(locked), 1);
    tick(2, 0, 0, 1);

    // lock_en dropped mid-hold
    tick(3, 0, 1, 1);
    tick(4, 0, 0, 1);
    chk("le_enter", 32'(holding), 1);
    for (int i = 5; i < 10; i++) tick(i, 0, 0, 1);
    tick(10, 0, 0, 0);
    chk("le_exit", 32'(holding), 0);
    chk("le_locked", 32'(locked), 0);

    // Asynchronous reset during hold
    tick(11, 0, 1, 1);
    tick(12, 0, 0, 1);
    tick(13, 0, 0, 1);
    chk("rh_enter", 32'(holding), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_async");
    model_reset();
    vga_hpos = '0; tia_vsync = 1'b0; vga_vsync = 1'b0; lock_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    @(negedge clk);
    reset = 1'b0;
    first = 0;
    for (int e = 1; e <= 7; e++) begin
      tick(0, 0, 0, 0);
      if (tia_en && first == 0) first = e;
    end
    chk("rst_first_tia", first, 7);

    // Random traffic
    g_hp = 0; tv = 0; vv = 0;
    for (int c = 0; c < 3000; c++) begin
      h = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 799)) : nh();
      if ($urandom_range(0, 29) == 0) tv = 1 - tv;
      if ($urandom_range(0, 199) == 0) vv = 1 - vv;
      le = ($urandom_range(0, 99) == 0) ? 0 : 1;
      tick(h, vv, tv, le);
    end
    tick(nh(), 0, 0, 0);

    // Miss counter saturation on the short-timeout instance
    for (int r = 0; r < 256; r++) begin
      s_lock = 1'b1; s_hpos = '0; s_tvsync = 1'b1;
      tick(nh(), 0, 0, 0);
      s_tvsync = 1'b0;
      tick(nh(), 0, 0, 0);
      chk("sat_enter", 32'(s_hold), 1);
      s_hpos = 10'(HX);
      cyc = 0;
      while (s_hold && cyc < 20) begin
        tick(nh(), 0, 0, 0);
        cyc++;
      end
      chk("sat_exit", 32'(s_hold), 0);
      chk("sat_miss", 32'(s_miss), (r + 1 > 255) ? 255 : r + 1);
      s_hpos = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atari_clock_scheduler.md
Name: atari_clock_scheduler

Overview:
- Central clock-enable and frame-lock controller for the Atari 2600 core running off the VGA pixel clock.
- Divides the pixel clock into a 21-cycle machine slot and emits registered strobes:
  - TIA colour-clock enable (3 per slot)
  - CPU enable and CPU phase level
  - PIA enable
- Realigns the slot to each VGA scanline and owns the line-buffer bank select.
- Holds the emulated machine after each TIA VSYNC until the VGA raster reaches its own VSYNC, so both frames start together.

Parameters:
- SLOT_LEN, 21, pixel clocks per CPU machine cycle
- TIA_PH1, 7, slot index of 2nd TIA strobe (1st is 0, 3rd is 2*TIA_PH1)
- PIA_PH, 16, slot index of PIA strobe; also end of CPU phase-high window
- HRESYNC_X, 798, VGA hpos at/after which slot is forced to 0
- TIMEOUT_LINES, 600, maximum scanlines spent in HOLD before forced resume

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- vga_hpos  in  10  VGA horizontal position
- vga_vsync  in  1  VGA vsync (active high)
- tia_vsync  in  1  TIA VSYNC output
- lock_en  in  1  1 = enable frame lock
- tia_en  out  1  TIA colour-clock enable pulse
- cpu_en  out  1  CPU enable pulse (slot 0)
- cpu_phase  out  1  CPU clock level, high for slots 0..PIA_PH-1
- pia_en  out  1  PIA enable pulse
- slot  out  5  current slot index
- line_bank  out  1  scanline buffer bank written by TIA (VGA reads ~line_bank)
- holding  out  1  FSM in HOLD
- locked  out  1  last HOLD exited via VGA vsync
- miss_count  out  8  HOLD timeouts, saturating

Behaviour:
- Reset (async): slot=0, every enable=0, cpu_phase=0, line_bank=0, state=RUN, holding=0, locked=0, miss_count=0, edge-detect registers=0, line counter=0.
- Slot counter, next value slot_n:
  - 0 if vga_hpos >= HRESYNC_X; this has priority over wrap.
  - Otherwise 0 if slot == SLOT_LEN-1.
  - Otherwise slot+1.
  - The counter runs in every state.
- Enables are registered, computed from slot_n and run_n (next state == RUN):
  - tia_en = run_n & (slot_n ∈ {0, TIA_PH1, 2*TIA_PH1})
  - cpu_en = run_n & (slot_n == 0)
  - pia_en = run_n & (slot_n == PIA_PH)
  - cpu_phase = run_n & (slot_n < PIA_PH)
  - Each pulse is therefore exactly one clock wide and coincides with the matching slot value.
- line_bank toggles on the clock where vga_hpos == HRESYNC_X.
- Edge detects: tia_fall = prev_tia_vsync & ~tia_vsync; vga_rise = ~prev_vga_vsync & vga_vsync. The prev registers update every clock.
- FSM RUN:
  - If lock_en & tia_fall & ~vga_rise, go to HOLD and clear the line counter.
  - tia_fall & vga_rise together: stay in RUN and set locked=1 (frames are already aligned).
- FSM HOLD:
  - All enables are 0 from the first HOLD clock onward; holding=1.
  - The line counter increments on each vga_hpos == HRESYNC_X.
  - vga_rise: go to RUN, set locked=1.
  - Otherwise, if the line counter reaches TIMEOUT_LINES: go to RUN, set locked=0, and increment miss_count, saturating at 255.
  - Otherwise, if ~lock_en: go to RUN, set locked=0.
  - vga_rise takes priority over timeout on the same clock.
- On returning to RUN, enables resume at the next decoded slot. No pulse is replayed and slot phase is preserved.
- lock_en=0 in RUN clears locked.
- Reset mid-HOLD returns immediately to RUN with all reset values.

Decomposition:
- Shared package atari_timing_pkg holds:
  - Slot constants SLOT_LEN, TIA_PH1, PIA_PH.
  - HRESYNC_X.
  - The FSM state enum {RUN, HOLD}.
- The top module also uses these constants.
- One natural sub-module, atari_frame_lock: the edge detectors, HOLD FSM, line counter and miss counter.
- The slot counter and enable decode stay in the parent.

Test Plan:
- Release reset with vga_hpos held at 0 and lock_en=0. Required:
  - First tia_en on the 7th rising edge; then on the 14th.
  - First cpu_en with slot=0 on the 21st edge; tia_en also high on that edge.
  - pia_en on the 16th edge.
  - cpu_phase high on edges 1–15 and 21; low on edges 16–20.
- Sweep vga_hpos 0..799 repeatedly. Required:
  - slot reads 0 while hpos = 798 and 799.
  - line_bank flips once per line.
  - 2 × 1600 pixel clocks contain exactly 456 tia_en pulses (228 per TIA line).
- lock_en=1, pulse tia_vsync 1→0, then raise vga_vsync 1000 clocks later. Required:
  - holding=1 and no enables throughout.
  - Exit to RUN on the vga_vsync rising edge with locked=1 and miss_count=0.
  - Slot phase continuous across the hold.
- lock_en=1, tia_vsync fall, and vga_vsync never rises. Required:
  - Forced exit after 600 line resyncs; locked=0, miss_count=1.
  - 256 repeats leave miss_count at 255.
- tia_vsync fall and vga_vsync rise on the same clock: state stays RUN and locked=1. Separately, deassert lock_en mid-HOLD: RUN on the next clock.
- Assert reset for 3 clocks mid-HOLD: all outputs read reset values asynchronously; the first tia_en after release comes 7 edges later.
